// File: rtl/sdram_ctrlmod.sv
// Command scheduler for the SDRAM function module: power-up init, periodic auto-refresh, user write/read arbitration.
// Optional missed-refresh flag oRefErr is compiled in when SDRAM_REF_ERR_EN is defined.
module sdram_ctrlmod #(
  parameter int                   WIDTH_CNT = 12,
  parameter logic [WIDTH_CNT-1:0] TREF      = 12'd2000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] iCall,
  output logic       oDone,
  output logic       oReady,
  output logic [3:0] oCall,
  input  logic       iDone
`ifdef SDRAM_REF_ERR_EN
  ,
  output logic       oRefErr
`endif
);

  typedef enum logic [2:0] {INIT, IDLE, REF, WR, RD, ACK} state_t;

  state_t               state;
  logic [WIDTH_CNT-1:0] ref_cnt;
  logic                 ref_pend;
  logic                 wrap;

  assign wrap = oReady && (ref_cnt == TREF - WIDTH_CNT'(1));

  // Refresh timer runs only after init; a wrap sets pending after any clear from entering REF.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= INIT;
      oCall    <= 4'b0000;
      oDone    <= 1'b0;
      oReady   <= 1'b0;
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
`ifdef SDRAM_REF_ERR_EN
      oRefErr  <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      if (oReady) begin
        ref_cnt <= wrap ? '0 : ref_cnt + WIDTH_CNT'(1);
      end

      case (state)
        INIT: begin
          if (iDone) begin
            oCall  <= 4'b0000;
            oReady <= 1'b1;
            state  <= IDLE;
          end else begin
            oCall <= 4'b0001;
          end
        end
        IDLE: begin
          if (ref_pend) begin
            state    <= REF;
            oCall    <= 4'b0010;
            ref_pend <= 1'b0;
          end else if (iCall[1]) begin
            state <= WR;
            oCall <= 4'b1000;
          end else if (iCall[0]) begin
            state <= RD;
            oCall <= 4'b0100;
          end else begin
            oCall <= 4'b0000;
          end
        end
        REF, WR, RD: begin
          // Dropping oCall on completion keeps the function module from re-running the command.
          if (iDone) begin
            oCall <= 4'b0000;
            if (state == REF) begin
              state <= IDLE;
            end else begin
              state <= ACK;
              oDone <= 1'b1;
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= INIT;
          oCall <= 4'b0000;
        end
      endcase

      if (wrap) begin
        ref_pend <= 1'b1;
      end
`ifdef SDRAM_REF_ERR_EN
      if (wrap && ref_pend) begin
        oRefErr <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Directed bench for sdram_ctrlmod with TREF=20; the bench plays the function module by pulsing iDone.
// Define SDRAM_REF_ERR_EN for both files to exercise oRefErr.
module tb_sdram_ctrlmod;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] iCall = 2'b00;
  logic       iDone = 1'b0;
  logic       oDone;
  logic       oReady;
  logic [3:0] oCall;
`ifdef SDRAM_REF_ERR_EN
  logic       oRefErr;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sdram_ctrlmod #(.WIDTH_CNT(12), .TREF(12'd20)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .iCall  (iCall),
    .oDone  (oDone),
    .oReady (oReady),
    .oCall  (oCall),
    .iDone  (iDone)
`ifdef SDRAM_REF_ERR_EN
    ,
    .oRefErr(oRefErr)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Reset, then complete init with iDone seen on edge n_init; cyc counts edges after init completes.
  task automatic restart(input int n_init, input logic [1:0] req);
    RESET = 1'b0;
    iCall = req;
    iDone = 1'b0;
    #3;
    chk("rst_call", oCall, 4'b0000);
    chk("rst_ready", 4'(oReady), 4'd0);
    chk("rst_done", 4'(oDone), 4'd0);
    tick();
    tick();
    RESET = 1'b1;
    for (int k = 1; k < n_init; k++) begin
      tick();
      chk("init_call", oCall, 4'b0001);
      chk("init_ready", 4'(oReady), 4'd0);
    end
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("init_end_call", oCall, 4'b0000);
    chk("init_end_ready", 4'(oReady), 4'd1);
    cyc = 0;
  endtask

  initial begin
    #1;
    $display("[TB] init sequence, 20-cycle function module");
    restart(20, 2'b00);

    $display("[TB] periodic refresh");
    for (int r = 0; r < 3; r++) begin
      run_to(20 + 20 * r);
      chk("ref_gap", oCall, 4'b0000);
      tick();
      chk("ref_call", oCall, 4'b0010);
      run_to(25 + 20 * r);
      chk("ref_hold", oCall, 4'b0010);
      iDone = 1'b1;
      tick();
      iDone = 1'b0;
      chk("ref_clear", oCall, 4'b0000);
      chk("ref_no_done", 4'(oDone), 4'd0);
    end

    $display("[TB] single write");
    restart(3, 2'b00);
    iCall = 2'b10;
    tick();
    chk("wr_call", oCall, 4'b1000);
    run_to(8);
    chk("wr_hold", oCall, 4'b1000);
    chk("wr_no_done", 4'(oDone), 4'd0);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("wr_clear", oCall, 4'b0000);
    chk("wr_done", 4'(oDone), 4'd1);
    iCall = 2'b00;
    tick();
    chk("wr_done_pulse", 4'(oDone), 4'd0);
    chk("wr_ack_call", oCall, 4'b0000);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("stray_done_call", oCall, 4'b0000);
    chk("stray_done_done", 4'(oDone), 4'd0);
    chk("stray_done_ready", 4'(oReady), 4'd1);

    $display("[TB] write and read together");
    restart(3, 2'b00);
    iCall = 2'b11;
    tick();
    chk("wr1_call", oCall, 4'b1000);
    tick();
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("wr1_done", 4'(oDone), 4'd1);
    iCall = 2'b01;
    tick();
    chk("wr1_ack", 4'(oDone), 4'd0);
    chk("wr1_ack_call", oCall, 4'b0000);
    tick();
    chk("rd2_call", oCall, 4'b0100);
    tick();
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("rd2_done", 4'(oDone), 4'd1);
    chk("rd2_clear", oCall, 4'b0000);
    iCall = 2'b00;
    tick();
    chk("rd2_ack", 4'(oDone), 4'd0);
    tick();
    chk("rd2_idle_call", oCall, 4'b0000);
    chk("rd2_idle_done", 4'(oDone), 4'd0);

    $display("[TB] refresh expires during read");
    restart(3, 2'b00);
    run_to(17);
    iCall = 2'b01;
    tick();
    chk("late_rd_call", oCall, 4'b0100);
    run_to(27);
    chk("late_rd_hold", oCall, 4'b0100);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("late_rd_done", 4'(oDone), 4'd1);
    iCall = 2'b10;
    tick();
    chk("late_ack_call", oCall, 4'b0000);
    tick();
    chk("ref_before_user", oCall, 4'b0010);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("late_ref_clear", oCall, 4'b0000);
    tick();
    chk("late_wr_call", oCall, 4'b1000);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_rst_call", oCall, 4'b0000);
    chk("async_rst_ready", 4'(oReady), 4'd0);

    $display("[TB] request held during init");
    restart(5, 2'b01);
    tick();
    chk("post_init_rd", oCall, 4'b0100);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    chk("post_init_done", 4'(oDone), 4'd1);
    iCall = 2'b00;
    tick();

`ifdef SDRAM_REF_ERR_EN
    $display("[TB] missed refresh flag");
    restart(3, 2'b00);
    chk("referr_reset", 4'(oRefErr), 4'd0);
    iCall = 2'b10;
    tick();
    chk("referr_wr", oCall, 4'b1000);
    run_to(39);
    chk("referr_before", 4'(oRefErr), 4'd0);
    tick();
    chk("referr_rise", 4'(oRefErr), 4'd1);
    run_to(45);
    chk("referr_wr_hold", oCall, 4'b1000);
    iDone = 1'b1;
    tick();
    iDone = 1'b0;
    iCall = 2'b00;
    tick();
    tick();
    chk("referr_sticky", 4'(oRefErr), 4'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("referr_clear", 4'(oRefErr), 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
